// File: rtl/cube_pkg.sv
// cube_pkg: cube sticker encoding, move codes and the face-turn permutation helper
package cube_pkg;
  localparam int STICKER_W = 3;
  localparam int FACE_W = 9 * STICKER_W;
  localparam int CUBE_W = 6 * FACE_W;
  localparam int FACE_U = 0;
  localparam int FACE_R = 1;
  localparam int FACE_F = 2;
  localparam int FACE_D = 3;
  localparam int FACE_L = 4;
  localparam int FACE_B = 5;
  localparam logic [3:0] MV_END = 4'd0;
  localparam logic [3:0] MV_NOP = 4'd1;
  localparam logic [3:0] MV_R = 4'd2;
  localparam logic [3:0] MV_RI = 4'd3;
  localparam logic [3:0] MV_U = 4'd4;
  localparam logic [3:0] MV_UI = 4'd5;
  localparam logic [3:0] MV_F = 4'd6;
  localparam logic [3:0] MV_FI = 4'd7;
  localparam logic [3:0] MV_L = 4'd8;
  localparam logic [3:0] MV_LI = 4'd9;
  localparam logic [3:0] MV_B = 4'd10;
  localparam logic [3:0] MV_BI = 4'd11;
  localparam logic [3:0] MV_D = 4'd12;
  localparam logic [3:0] MV_DI = 4'd13;
  // face turned by codes 2..13, indexed by code[3:1]-1
  localparam int TURN_FACE [6] = '{FACE_R, FACE_U, FACE_F, FACE_L, FACE_B, FACE_D};
  // adjacent sticker ring per face; a clockwise turn moves entry i to entry i+3
  localparam int RING [6][12] = '{
    '{18, 19, 20, 36, 37, 38, 45, 46, 47,  9, 10, 11},
    '{20, 23, 26,  2,  5,  8, 51, 48, 45, 29, 32, 35},
    '{ 6,  7,  8,  9, 12, 15, 29, 28, 27, 44, 41, 38},
    '{24, 25, 26, 15, 16, 17, 51, 52, 53, 42, 43, 44},
    '{ 0,  3,  6, 18, 21, 24, 27, 30, 33, 53, 50, 47},
    '{ 0,  1,  2, 42, 39, 36, 35, 34, 33, 11, 14, 17}};

  function automatic logic is_rotation(input logic [3:0] code);
    return code >= MV_R && code <= MV_DI;
  endfunction

  function automatic logic [CUBE_W-1:0] rotate_face(input logic [CUBE_W-1:0] s, input int f, input logic ccw);
    rotate_face = s;
    for (int i = 0; i < 9; i++)
      rotate_face[(f*9+i)*STICKER_W +: STICKER_W] =
        s[(f*9+(ccw ? (i%3)*3+2-i/3 : (2-i%3)*3+i/3))*STICKER_W +: STICKER_W];
    for (int i = 0; i < 12; i++)
      rotate_face[RING[f][ccw ? i : (i+3)%12]*STICKER_W +: STICKER_W] =
        s[RING[f][ccw ? (i+3)%12 : i]*STICKER_W +: STICKER_W];
  endfunction
endpackage

// File: rtl/cube_turn.sv
// cube_turn: combinational single quarter-turn of the cube state for one move code
module cube_turn
  import cube_pkg::*;
(
  input  logic [CUBE_W-1:0] state,
  input  logic [3:0]        code,
  output logic [CUBE_W-1:0] next_state
);
  logic [CUBE_W-1:0] rot [6][2];
  logic [2:0] sel;
  for (genvar g = 0; g < 6; g++) begin : g_face
    for (genvar d = 0; d < 2; d++) begin : g_dir
      assign rot[g][d] = rotate_face(state, TURN_FACE[g], d == 1);
    end
  end
  always_comb begin
    sel = is_rotation(code) ? code[3:1] - 3'd1 : 3'd0;
    next_state = is_rotation(code) ? rot[sel][code[0]] : state;
  end
endmodule

// File: rtl/update_state_seq.sv
// update_state_seq: applies a latched move list to a latched cube state, one move per clock
module update_state_seq
  import cube_pkg::*;
#(
  parameter int MAX_MOVES = 50,
  parameter int MOVE_W = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [MAX_MOVES*MOVE_W-1:0]   moves,
  input  logic                          new_moves_ready,
  input  logic [CUBE_W-1:0]             cubestate,
  output logic [CUBE_W-1:0]             cubestate_updated,
  output logic                          state_updated,
  output logic                          busy,
  output logic [6:0]                    moves_applied
);
  localparam int LIST_W = MAX_MOVES * MOVE_W;
  localparam logic [6:0] LAST = 7'(MAX_MOVES - 1);
  typedef enum logic {IDLE, MOVING} fsm_t;
  fsm_t fsm;
  logic [LIST_W-1:0] list;
  logic [CUBE_W-1:0] work, turned;
  logic [6:0] pos;
  logic [3:0] code;
  assign code = 4'(list[LIST_W-1 -: MOVE_W]);
  assign busy = fsm == MOVING;
  cube_turn u_turn (.state(work), .code(code), .next_state(turned));
  always_ff @(posedge clock) begin
    if (reset) begin
      fsm <= IDLE;
      list <= '0;
      work <= '0;
      pos <= '0;
      cubestate_updated <= '0;
      state_updated <= 1'b0;
      moves_applied <= '0;
    end else begin
      state_updated <= 1'b0;
      if (fsm == IDLE) begin
        if (new_moves_ready) begin
          list <= moves;
          work <= cubestate;
          pos <= '0;
          moves_applied <= '0;
          fsm <= MOVING;
        end
      end else begin
        list <= list << MOVE_W;
        pos <= pos + 7'd1;
        work <= turned;
        if (is_rotation(code)) moves_applied <= moves_applied + 7'd1;
        if (code == MV_END || pos == LAST) begin
          cubestate_updated <= turned;
          state_updated <= 1'b1;
          fsm <= IDLE;
        end
      end
    end
  end
endmodule

// File: doc/update_state_seq.md
UPDATE_STATE_SEQ -- requirements
Module: update_state_seq

Interface
REQ-001 SHALL have parameter MAX_MOVES, default 50, the move-list capacity in moves (legal range 1..127).
REQ-002 SHALL have parameter MOVE_W, default 4, the bits per move code.
REQ-003 SHALL have port clock  input  1  the single clock, all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port moves  input  MAX_MOVES*MOVE_W  the move list; first move in the most significant MOVE_W bits.
REQ-006 SHALL have port new_moves_ready  input  1  start request, sampled only in IDLE.
REQ-007 SHALL have port cubestate  input  162  the starting cube state.
REQ-008 SHALL have port cubestate_updated  output  162  the result of the last completed sequence.
REQ-009 SHALL have port state_updated  output  1  a one-cycle completion pulse.
REQ-010 SHALL have port busy  output  1  high in every state except IDLE.
REQ-011 SHALL have port moves_applied  output  7  the count of rotations applied in the last or current sequence.

Function
REQ-012 Cube encoding SHALL be 54 stickers of 3 bits each; face f occupies bits [f*27 +: 27], with U=0, R=1, F=2, D=3, L=4, B=5.
REQ-013 Within a face, sticker s (0..8, row-major as viewed facing that face, U viewed with B at top, D viewed with F at top) SHALL occupy bits [f*27+s*3 +: 3].
REQ-014 Move codes SHALL be: 0 END, 1 NOP, 2 R, 3 Ri, 4 U, 5 Ui, 6 F, 7 Fi, 8 L, 9 Li, 10 B, 11 Bi, 12 D, 13 Di; codes 14 and 15 SHALL be treated as NOP.
REQ-015 Each non-i move SHALL rotate its face 90 degrees clockwise as viewed facing that face; each i move SHALL rotate it counter-clockwise.
REQ-016 The FSM SHALL have states IDLE and MOVING.
REQ-017 In IDLE with new_moves_ready=1, the block SHALL latch moves and cubestate into internal registers, clear moves_applied, and enter MOVING on the same edge.
REQ-018 In MOVING, each edge SHALL consume the top MOVE_W bits of the list, shift the list left by MOVE_W, and increment the position counter.
REQ-019 Each consumed rotation code (2..13) SHALL update the working state and increment moves_applied; NOP SHALL consume one cycle with no state change.
REQ-020 Termination SHALL occur on the edge that consumes END or consumes position MAX_MOVES-1, whichever comes first.
REQ-021 On the terminating edge the block SHALL load cubestate_updated from the working state, set state_updated=1, and go to IDLE.
REQ-022 state_updated SHALL be high for exactly one cycle per accepted request.
REQ-023 Latency SHALL be: request accepted at edge k, list terminating at position j (0-based) -> state_updated high in the cycle after edge k+j+1.
REQ-024 An END-first list SHALL produce state_updated after edge k+1, with cubestate_updated equal to cubestate and moves_applied=0.
REQ-025 new_moves_ready SHALL be ignored while busy; inputs changing during MOVING SHALL NOT affect the result.
REQ-026 new_moves_ready held high SHALL be accepted again in the cycle state_updated is high, since the block is then in IDLE.
REQ-027 cubestate_updated SHALL hold its value until the next completion.

Reset
REQ-028 On reset the block SHALL set state to IDLE and drive cubestate_updated=0, state_updated=0, busy=0, moves_applied=0.
REQ-029 Reset during MOVING SHALL abort the sequence with no state_updated pulse, and SHALL take priority over new_moves_ready.

Structure
REQ-030 Move-code constants, face indices and the sticker width SHALL reside in shared package cube_pkg.
REQ-031 Rotations SHALL be implemented in a combinational sub-module cube_turn (inputs state[161:0] and code[3:0], output the next state).
REQ-032 The sequential block SHALL contain only the FSM, the working-state register, the shift register and the counters.

Verification
REQ-033 Solved state (face f stickers = f), list {U, END} -> F stickers 0..2 = 1, other F stickers = 2, state_updated after 2 cycles, moves_applied=1.
REQ-034 Solved state, list {R,Ri,F,Fi,L,Li,B,Bi,D,Di,U,Ui,END} -> cubestate_updated equals the input, moves_applied=12.
REQ-035 Scrambled state, all 50 slots R (no END) -> cubestate_updated equals R^2 of the input, state_updated exactly 50 cycles after accept.
REQ-036 List {NOP,14,15,END} -> output equals the input, moves_applied=0, state_updated after 4 cycles.
REQ-037 Reset asserted on the 3rd MOVING cycle -> no pulse, all outputs 0; a new request 1 cycle later completes normally.
REQ-038 new_moves_ready held high continuously -> back-to-back sequences, each pulse one cycle wide, and input changes during MOVING are ignored.
